four_12_12_tap_mem_arb: RTL and testbench
=========================================

Name: four_12_12_tap_mem_arb

Overview:
- Arbitrates the single-port tap memory (tap_int, 384-bit x 32) of a stage controller between three requesters:
  - forward-pass tap read (fwd)
  - error back-propagation tap read (bwd)
  - tap-update write (upd)
- Issues at most one memory command per cycle and routes read data back to the owning requester after a fixed latency.
- Sits between the stage out-control logic and the tap memory instance.

Parameters:
- DATA_W, 384, tap word width (12 taps x 32b float_24_8).
- ADDR_W, 5, tap memory address width.
- RD_LAT, 1, memory read latency in cycles (1..4).
- MAX_WAIT, 4, consecutive blocked cycles after which a read requester overrides upd priority.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- upd_enable  in  1  tap update enable from the stage config; when 0, upd_req is ignored.
- fwd_req  in  1  forward read request (level, held until granted).
- fwd_addr  in  ADDR_W  forward read address.
- fwd_gnt  out  1  forward grant.
- fwd_rd_vld  out  1  forward read data valid.
- fwd_rd_data  out  DATA_W  forward read data.
- bwd_req / bwd_addr / bwd_gnt / bwd_rd_vld / bwd_rd_data  same shapes as fwd; back-prop read.
- upd_req  in  1  update write request.
- upd_addr  in  ADDR_W  write address.
- upd_wr_data  in  DATA_W  write data.
- upd_gnt  out  1  write grant.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_rd_data  in  DATA_W  memory read data, valid RD_LAT cycles after a read command.
- busy  out  1  any read in flight or any request pending.

Behaviour:
- Handshake:
  - A transfer occurs in the cycle where req and gnt are both high.
  - A requester holds req and addr/data stable until granted.
  - Grants are combinational from req and registered arbiter state.
  - At most one gnt is high per cycle.
- Memory command:
  - In the grant cycle, mem_en=1, mem_addr = the winner's address.
  - For upd: mem_wr=1 and mem_wr_data=upd_wr_data.
  - With no grant: mem_en=0, mem_wr=0, address and data hold their last value.
- Priority, evaluated each cycle:
  1. A read requester whose wait counter equals MAX_WAIT wins. If both fwd and bwd are starved, the round-robin pointer picks.
  2. Otherwise upd (if upd_req and upd_enable).
  3. Otherwise fwd/bwd round-robin. rr_last records the last granted read requester; the other one wins a tie.
- Wait counters (fwd, bwd):
  - Saturating at MAX_WAIT.
  - Increment when req=1 and gnt=0.
  - Clear on grant or when req=0.
- Read return:
  - A tag pipeline RD_LAT deep carries {vld, owner}.
  - rd_vld of the owner pulses exactly RD_LAT cycles after its grant; rd_data = mem_rd_data in that cycle.
  - Both rd_data outputs carry mem_rd_data; only the owner's vld is asserted.
- Ordering: commands execute in grant order. A read granted after a write to the same address returns the new data; no forwarding is required.
- upd_enable=0 with upd_req=1: upd_gnt stays 0, no write, and upd does not block reads.
- Back-to-back grants to the same requester on consecutive cycles are legal; throughput is 1 command per cycle.
- Reset values: all gnt=0, rd_vld=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wr_data=0, busy=0, rr_last=bwd (so fwd wins the first tie), wait counters=0, tag pipeline cleared.
- Reset mid-operation: in-flight reads are dropped. No rd_vld is asserted after reset deasserts for commands issued before it.

Optional Feature:
- Macro: TAP_ARB_STATS_EN.
- Defined: adds outputs stat_fwd_cnt, stat_bwd_cnt, stat_upd_cnt (16-bit, saturating grant counts) and stat_starve_cnt (16-bit, saturating count of starvation-override grants), plus input stat_clr (synchronous clear, priority over increment). All counters reset to 0.
- Undefined: these ports and counters do not exist; arbitration is unchanged.

Decomposition:
- Shared package: tap_req_e enum {REQ_FWD=0, REQ_BWD=1, REQ_UPD=2}; TAP_DATA_W=384, TAP_ADDR_W=5 constants; the default MAX_WAIT constant.
- Sub-module four_12_12_tap_rd_tag_pipe: an RD_LAT-deep shift register of {vld, tap_req_e owner} with asynchronous active-low reset, decoding the per-requester rd_vld.

Test Plan:
- Single read: fwd_req with addr 7, memory preloaded word 0xA5.. at addr 7, RD_LAT=1 -> fwd_gnt in cycle 0; fwd_rd_vld in cycle 1 with data 0xA5..; bwd_rd_vld stays 0.
- Round-robin: fwd_req and bwd_req held for 4 cycles after reset, upd idle -> grant order fwd, bwd, fwd, bwd.
- Starvation: upd_req held 10 cycles with upd_enable=1 and fwd_req held, MAX_WAIT=4 -> upd granted for 4 cycles, fwd granted in cycle 4, then upd resumes.
- Write-then-read: upd writes 0x1234.. to addr 3, then bwd reads addr 3 in the next cycle -> bwd_rd_data=0x1234...
- upd_enable=0 with upd_req=1 and fwd_req=1 -> upd_gnt never asserts, mem_wr stays 0, fwd is granted immediately.
- Reset mid-flight: RD_LAT=3, fwd granted, reset asserted 1 cycle later for 2 cycles -> no fwd_rd_vld ever appears; all outputs are 0 during reset.

Source files
------------

// File: rtl/four_12_12_tap_mem_arb_pkg.sv
// Shared types and constants for the tap memory arbiter.
package four_12_12_tap_mem_arb_pkg;

  localparam int TAP_DATA_W   = 384;
  localparam int TAP_ADDR_W   = 5;
  localparam int TAP_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    REQ_FWD = 2'd0,
    REQ_BWD = 2'd1,
    REQ_UPD = 2'd2
  } tap_req_e;

  // The read requester that wins a fwd/bwd tie, given the last read winner.
  function automatic tap_req_e rr_other(input tap_req_e last);
    return (last == REQ_FWD) ? REQ_BWD : REQ_FWD;
  endfunction

endpackage

// File: rtl/four_12_12_tap_rd_tag_pipe.sv
// Read-return tag pipeline: RD_LAT-deep {vld, owner} shift register that
// decodes the per-requester read-data-valid strobes.
module four_12_12_tap_rd_tag_pipe
  import four_12_12_tap_mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_vld,
  input  tap_req_e in_owner,
  output logic     fwd_rd_vld,
  output logic     bwd_rd_vld,
  output logic     any_vld
);

  logic [RD_LAT:1]       vld_pipe;
  logic [RD_LAT:1][1:0]  own_pipe;
  tap_req_e              out_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      for (int s = RD_LAT; s > 1; s--) begin
        vld_pipe[s] <= vld_pipe[s-1];
        own_pipe[s] <= own_pipe[s-1];
      end
      vld_pipe[1] <= in_vld;
      own_pipe[1] <= in_owner;
    end
  end

  assign out_owner  = tap_req_e'(own_pipe[RD_LAT]);
  assign fwd_rd_vld = vld_pipe[RD_LAT] && (out_owner == REQ_FWD);
  assign bwd_rd_vld = vld_pipe[RD_LAT] && (out_owner == REQ_BWD);
  assign any_vld    = |vld_pipe;

endmodule

// File: rtl/four_12_12_tap_mem_arb.sv
// Single-port tap memory arbiter: fwd/bwd reads and upd writes, one command
// per cycle. Optional grant statistics under TAP_ARB_STATS_EN.
module four_12_12_tap_mem_arb
  import four_12_12_tap_mem_arb_pkg::*;
#(
  parameter int DATA_W   = TAP_DATA_W,
  parameter int ADDR_W   = TAP_ADDR_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = TAP_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_enable,
  input  logic              fwd_req,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_gnt,
  output logic              fwd_rd_vld,
  output logic [DATA_W-1:0] fwd_rd_data,
  input  logic              bwd_req,
  input  logic [ADDR_W-1:0] bwd_addr,
  output logic              bwd_gnt,
  output logic              bwd_rd_vld,
  output logic [DATA_W-1:0] bwd_rd_data,
  input  logic              upd_req,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_wr_data,
  output logic              upd_gnt,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
`ifdef TAP_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_fwd_cnt,
  output logic [15:0]       stat_bwd_cnt,
  output logic [15:0]       stat_upd_cnt,
  output logic [15:0]       stat_starve_cnt
`endif
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

  logic [WCW-1:0]    fwd_wait, bwd_wait;
  tap_req_e          rr_last;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              upd_act, fwd_starve, bwd_starve, rr_fwd;
  logic              g_fwd, g_bwd, g_upd, starve_win, rd_gnt;
  logic              rd_inflight;

  assign upd_act    = upd_req && upd_enable;
  assign fwd_starve = fwd_req && (fwd_wait == WAIT_SAT);
  assign bwd_starve = bwd_req && (bwd_wait == WAIT_SAT);
  assign rr_fwd     = (rr_other(rr_last) == REQ_FWD);

  // Grants are forced low while reset is held so the memory sees no command.
  always_comb begin
    g_fwd      = 1'b0;
    g_bwd      = 1'b0;
    g_upd      = 1'b0;
    starve_win = 1'b0;
    if (reset) begin
      if (fwd_starve || bwd_starve) begin
        starve_win = 1'b1;
        if (fwd_starve && bwd_starve) begin
          g_fwd = rr_fwd;
          g_bwd = !rr_fwd;
        end else begin
          g_fwd = fwd_starve;
          g_bwd = bwd_starve;
        end
      end else if (upd_act) begin
        g_upd = 1'b1;
      end else if (fwd_req && bwd_req) begin
        g_fwd = rr_fwd;
        g_bwd = !rr_fwd;
      end else begin
        g_fwd = fwd_req;
        g_bwd = bwd_req;
      end
    end
  end

  assign fwd_gnt = g_fwd;
  assign bwd_gnt = g_bwd;
  assign upd_gnt = g_upd;
  assign rd_gnt  = g_fwd || g_bwd;

  assign mem_en      = rd_gnt || g_upd;
  assign mem_wr      = g_upd;
  assign mem_addr    = g_upd ? upd_addr : g_bwd ? bwd_addr : g_fwd ? fwd_addr : addr_q;
  assign mem_wr_data = g_upd ? upd_wr_data : wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rr_last  <= REQ_BWD;
      fwd_wait <= '0;
      bwd_wait <= '0;
    end else begin
      if (mem_en) addr_q <= mem_addr;
      if (g_upd)  wdata_q <= upd_wr_data;
      if (rd_gnt) rr_last <= g_fwd ? REQ_FWD : REQ_BWD;

      if (!fwd_req || g_fwd)       fwd_wait <= '0;
      else if (fwd_wait != WAIT_SAT) fwd_wait <= fwd_wait + 1'b1;

      if (!bwd_req || g_bwd)       bwd_wait <= '0;
      else if (bwd_wait != WAIT_SAT) bwd_wait <= bwd_wait + 1'b1;
    end
  end

  four_12_12_tap_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk        (clk),
    .rst_n      (reset),
    .in_vld     (rd_gnt),
    .in_owner   (g_bwd ? REQ_BWD : REQ_FWD),
    .fwd_rd_vld (fwd_rd_vld),
    .bwd_rd_vld (bwd_rd_vld),
    .any_vld    (rd_inflight)
  );

  assign fwd_rd_data = reset ? mem_rd_data : '0;
  assign bwd_rd_data = reset ? mem_rd_data : '0;
  assign busy        = reset && (rd_inflight || fwd_req || bwd_req || upd_act);

`ifdef TAP_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fwd_cnt    <= '0;
      stat_bwd_cnt    <= '0;
      stat_upd_cnt    <= '0;
      stat_starve_cnt <= '0;
    end else if (stat_clr) begin
      stat_fwd_cnt    <= '0;
      stat_bwd_cnt    <= '0;
      stat_upd_cnt    <= '0;
      stat_starve_cnt <= '0;
    end else begin
      if (g_fwd) stat_fwd_cnt <= sat_inc(stat_fwd_cnt);
      if (g_bwd) stat_bwd_cnt <= sat_inc(stat_bwd_cnt);
      if (g_upd) stat_upd_cnt <= sat_inc(stat_upd_cnt);
      if (starve_win && rd_gnt) stat_starve_cnt <= sat_inc(stat_starve_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_four_12_12_tap_mem_arb.sv
// Scoreboard bench: two arbiters (RD_LAT=1 and RD_LAT=3) share stimulus and
// a behavioural tap memory; expected reads are queued at grant time.
module tb_four_12_12_tap_mem_arb;
  import four_12_12_tap_mem_arb_pkg::*;

  localparam int DW = 384;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          upd_enable, fwd_req, bwd_req, upd_req;
  logic [AW-1:0] fwd_addr, bwd_addr, upd_addr;
  logic [DW-1:0] upd_wr_data;

  logic          a_fwd_gnt, a_fwd_vld, a_bwd_gnt, a_bwd_vld, a_upd_gnt, a_en, a_wr, a_busy;
  logic [DW-1:0] a_fwd_rd, a_bwd_rd, a_wdata, a_rdata;
  logic [AW-1:0] a_addr;
  logic          c_fwd_gnt, c_fwd_vld, c_bwd_gnt, c_bwd_vld, c_upd_gnt, c_en, c_wr, c_busy;
  logic [DW-1:0] c_fwd_rd, c_bwd_rd, c_wdata, c_rdata;
  logic [AW-1:0] c_addr;

  typedef struct {
    tap_req_e      owner;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] c_s [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  four_12_12_tap_mem_arb #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .upd_enable(upd_enable),
    .fwd_req(fwd_req), .fwd_addr(fwd_addr), .fwd_gnt(a_fwd_gnt),
    .fwd_rd_vld(a_fwd_vld), .fwd_rd_data(a_fwd_rd),
    .bwd_req(bwd_req), .bwd_addr(bwd_addr), .bwd_gnt(a_bwd_gnt),
    .bwd_rd_vld(a_bwd_vld), .bwd_rd_data(a_bwd_rd),
    .upd_req(upd_req), .upd_addr(upd_addr), .upd_wr_data(upd_wr_data), .upd_gnt(a_upd_gnt),
    .mem_en(a_en), .mem_wr(a_wr), .mem_addr(a_addr), .mem_wr_data(a_wdata),
    .mem_rd_data(a_rdata), .busy(a_busy)
  );

  four_12_12_tap_mem_arb #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .upd_enable(upd_enable),
    .fwd_req(fwd_req), .fwd_addr(fwd_addr), .fwd_gnt(c_fwd_gnt),
    .fwd_rd_vld(c_fwd_vld), .fwd_rd_data(c_fwd_rd),
    .bwd_req(bwd_req), .bwd_addr(bwd_addr), .bwd_gnt(c_bwd_gnt),
    .bwd_rd_vld(c_bwd_vld), .bwd_rd_data(c_bwd_rd),
    .upd_req(upd_req), .upd_addr(upd_addr), .upd_wr_data(upd_wr_data), .upd_gnt(c_upd_gnt),
    .mem_en(c_en), .mem_wr(c_wr), .mem_addr(c_addr), .mem_wr_data(c_wdata),
    .mem_rd_data(c_rdata), .busy(c_busy)
  );

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 5'd7) ? {48{8'hA5}} : {12{8'hC0, 19'h0, a}};
  endfunction

  // Memory written by dut1's commands; both DUTs issue the same command stream.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(AW'(i));
    end else if (a_en && a_wr) begin
      mem[a_addr] <= a_wdata;
    end
    if (a_en && !a_wr) a_rdata <= mem[a_addr];
    if (c_en && !c_wr) c_s[0] <= mem[c_addr];
    c_s[1] <= c_s[0];
    c_s[2] <= c_s[1];
  end
  assign c_rdata = c_s[2];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic gnt_chk(input string tag, input bit f, input bit b, input bit u);
    @(negedge clk);
    chk(tag, {a_fwd_gnt, a_bwd_gnt, a_upd_gnt}, {f, b, u});
    chk({tag, "_l3"}, {c_fwd_gnt, c_bwd_gnt, c_upd_gnt}, {f, b, u});
  endtask

  task automatic exp_rd(input tap_req_e owner, input logic [DW-1:0] data);
    q1.push_back('{owner, data, cyc + 1});
    q3.push_back('{owner, data, cyc + 3});
  endtask

  task automatic sb_check(input bit sel, input logic fv, input logic bv,
                          input logic [DW-1:0] fd, input logic [DW-1:0] bd);
    exp_t e;
    int   sz;
    sz = sel ? q3.size() : q1.size();
    if (fv || bv) begin
      if (sz == 0) begin
        chk(sel ? "rd_unexp_l3" : "rd_unexp", {fv, bv}, 2'b00);
      end else begin
        e = sel ? q3.pop_front() : q1.pop_front();
        chk(sel ? "rd_own_l3" : "rd_own", {fv, bv}, (e.owner == REQ_FWD) ? 2'b10 : 2'b01);
        chk(sel ? "rd_data_l3" : "rd_data", fv ? fd : bd, e.data);
        chk(sel ? "rd_lat_l3" : "rd_lat", cyc, e.due);
      end
    end else if (sz != 0) begin
      e = sel ? q3[0] : q1[0];
      if (e.due < cyc) begin
        chk(sel ? "rd_miss_l3" : "rd_miss", 1'b0, 1'b1);
        if (sel) void'(q3.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    sb_check(1'b0, a_fwd_vld, a_bwd_vld, a_fwd_rd, a_bwd_rd);
    sb_check(1'b1, c_fwd_vld, c_bwd_vld, c_fwd_rd, c_bwd_rd);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] wd;
    upd_enable = 1'b1;
    fwd_req = 0; bwd_req = 0; upd_req = 0;
    fwd_addr = '0; bwd_addr = '0; upd_addr = '0; upd_wr_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {a_fwd_gnt, a_bwd_gnt, a_upd_gnt, c_fwd_gnt, c_bwd_gnt, c_upd_gnt}, 0);
    chk("rst_cmd", {a_en, a_wr, a_busy, a_fwd_vld, a_bwd_vld, c_en, c_wr, c_busy}, 0);
    chk("rst_addr", {a_addr, c_addr}, 0);
    chk("rst_wdata", a_wdata, 0);
    tick();
    reset = 1'b1;

    // Round robin straight out of reset: fwd wins the first tie.
    fwd_req = 1; fwd_addr = 5'd1; bwd_req = 1; bwd_addr = 5'd2;
    for (int i = 0; i < 4; i++) begin
      gnt_chk("rr", (i % 2) == 0, (i % 2) == 1, 1'b0);
      if ((i % 2) == 0) exp_rd(REQ_FWD, init_word(5'd1));
      else              exp_rd(REQ_BWD, init_word(5'd2));
      tick();
    end
    fwd_req = 0; bwd_req = 0;
    idle(4);

    // Single read at addr 7.
    fwd_req = 1; fwd_addr = 5'd7;
    gnt_chk("rd1", 1, 0, 0);
    chk("rd1_cmd", {a_en, a_wr, a_addr}, {1'b1, 1'b0, 5'd7});
    chk("rd1_busy", a_busy, 1'b1);
    exp_rd(REQ_FWD, {48{8'hA5}});
    tick();
    fwd_req = 0; fwd_addr = 5'd0;
    @(negedge clk);
    chk("rd1_hold", {a_en, a_wr, a_addr}, {1'b0, 1'b0, 5'd7});
    idle(4);
    @(negedge clk);
    chk("idle_busy", {a_busy, c_busy}, 2'b00);
    tick();

    // Starvation override of upd priority.
    upd_req = 1; upd_addr = 5'd10; upd_wr_data = {12{32'hDEADBEEF}};
    fwd_req = 1; fwd_addr = 5'd5;
    for (int i = 0; i < 10; i++) begin
      gnt_chk("starve", (i == 4) || (i == 9), 1'b0, !((i == 4) || (i == 9)));
      if ((i == 4) || (i == 9)) exp_rd(REQ_FWD, init_word(5'd5));
      tick();
    end
    upd_req = 0; fwd_req = 0;
    idle(4);

    // Write then read the same address on the next cycle.
    wd = {12{32'h12345678}};
    upd_req = 1; upd_addr = 5'd3; upd_wr_data = wd;
    gnt_chk("wr", 0, 0, 1);
    chk("wr_cmd", {a_en, a_wr, a_addr}, {1'b1, 1'b1, 5'd3});
    chk("wr_data", a_wdata, wd);
    tick();
    upd_req = 0; upd_wr_data = '0; bwd_req = 1; bwd_addr = 5'd3;
    gnt_chk("wr_rd", 0, 1, 0);
    chk("wr_rd_wr", a_wr, 1'b0);
    chk("wr_hold", a_wdata, wd);
    exp_rd(REQ_BWD, wd);
    tick();
    bwd_req = 0;
    idle(4);

    // upd_enable low: upd ignored, fwd granted back to back.
    upd_enable = 0; upd_req = 1; upd_addr = 5'd12; upd_wr_data = {12{32'h0BADF00D}};
    fwd_req = 1; fwd_addr = 5'd9;
    for (int i = 0; i < 2; i++) begin
      gnt_chk("upd_off", 1, 0, 0);
      chk("upd_off_wr", a_wr, 1'b0);
      exp_rd(REQ_FWD, init_word(5'd9));
      tick();
    end
    fwd_req = 0;
    for (int i = 0; i < 2; i++) begin
      gnt_chk("upd_off_idle", 0, 0, 0);
      chk("upd_off_en", {a_en, a_wr}, 2'b00);
      tick();
    end
    @(negedge clk);
    chk("upd_off_busy", a_busy, 1'b0);
    tick();
    upd_req = 0; upd_enable = 1;
    idle(4);

    // Reset mid-flight: granted reads must never return.
    fwd_req = 1; fwd_addr = 5'd7;
    gnt_chk("rst_mid", 1, 0, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_out", {a_fwd_gnt, a_bwd_gnt, a_upd_gnt, a_fwd_vld, a_bwd_vld, a_en, a_wr, a_busy,
                      c_fwd_gnt, c_bwd_gnt, c_upd_gnt, c_fwd_vld, c_bwd_vld, c_en, c_wr, c_busy}, 0);
      chk("rst_out_addr", {a_addr, c_addr}, 0);
      chk("rst_out_data", c_fwd_rd | c_bwd_rd | c_wdata, 0);
      tick();
    end
    reset = 1'b1; fwd_req = 0;
    idle(8);
    @(negedge clk);
    chk("rst_busy", {a_busy, c_busy}, 2'b00);
    chk("sb_drain", q1.size() + q3.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
